// File: rtl/r5fp_int_mul_sq.sv
// r5fp_int_mul_sq
//   Iterative radix-4 unsigned multiplier/squarer. Returns the full 2W-bit
//   product A*B (or A*A in square mode). Each cycle retires two multiplier
//   bits. It uses the same strobe/ready/done handshake as the div/sqrt unit.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   A_i        multiplicand, captured when strobe_i=1
//   B_i        multiplier, captured when strobe_i=1 and is_sq_i=0
//   strobe_i   start request; restarts the unit even while it is busy
//   is_sq_i    1: A_i*A_i, 0: A_i*B_i (captured with strobe_i)
//   Prod_hi_o  product[2W-1:W], zero unless done_o
//   Prod_lo_o  product[W-1:0],  zero unless done_o
//   done_o     one-cycle pulse when the product is valid
//   ready_o    high when no operation is in flight
module r5fp_int_mul_sq #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] A_i,
  input  logic [W-1:0] B_i,
  input  logic         strobe_i,
  input  logic         is_sq_i,
  output logic [W-1:0] Prod_hi_o,
  output logic [W-1:0] Prod_lo_o,
  output logic         done_o,
  output logic         ready_o
);

  localparam int unsigned CNT_W = $clog2(W / 2 + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W / 2 - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     m_q;
  logic [W+1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic [W+1:0]     sum_d;
  logic [W+1:0]     acc_d;
  logic [W-1:0]     m_d;

  // The two low sum bits become finished product bits. They shift into the
  // top of M_r while the consumed multiplier bits leave at the bottom, so
  // after W/2 steps M_r holds the low product half.
  always_comb begin
    sum_d = acc_q + ({2'b00, a_q} * (W + 2)'(m_q[1:0]));
    acc_d = sum_d >> 2;
    m_d   = {sum_d[1:0], m_q[W-1:2]};
  end

  // Priority is reset, then strobe (start or abort-and-restart), then
  // iteration. The datapath registers are not reset because every output
  // that depends on them is gated by done_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (strobe_i) begin
      a_q     <= A_i;
      m_q     <= is_sq_i ? A_i : B_i;
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_BUSY;
      done_q  <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      acc_q <= acc_d;
      m_q   <= m_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        done_q  <= 1'b1;
        state_q <= ST_IDLE;
      end else begin
        done_q <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o    = done_q;
  assign ready_o   = (state_q == ST_IDLE);
  assign Prod_hi_o = done_q ? acc_q[W-1:0] : '0;
  assign Prod_lo_o = done_q ? m_q : '0;

  a_width_ok : assert property (@(posedge clk) ((W % 2) == 0) && (W >= 4));

  // ACC_r stays below 2^W, so its top two bits are zero when the result is read.
  a_acc_top_zero : assert property (@(posedge clk) done_q |-> (acc_q[W+1:W] == 2'b00));

endmodule

// File: tb/tb_r5fp_int_mul_sq.sv
module tb_r5fp_int_mul_sq;

  logic clk = 1'b0;
  logic reset;

  logic [7:0] a8, b8, hi8, lo8;
  logic       strobe8, sq8, done8, ready8;

  logic [5:0] a6, b6, hi6, lo6;
  logic       strobe6, sq6, done6, ready6;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] exp8_q[$];
  logic [11:0] exp6_q[$];

  always #5 clk = ~clk;

  r5fp_int_mul_sq #(.W(8)) u_dut8 (
    .clk(clk), .reset(reset), .A_i(a8), .B_i(b8), .strobe_i(strobe8), .is_sq_i(sq8),
    .Prod_hi_o(hi8), .Prod_lo_o(lo8), .done_o(done8), .ready_o(ready8)
  );

  r5fp_int_mul_sq #(.W(6)) u_dut6 (
    .clk(clk), .reset(reset), .A_i(a6), .B_i(b6), .strobe_i(strobe6), .is_sq_i(sq6),
    .Prod_hi_o(hi6), .Prod_lo_o(lo6), .done_o(done6), .ready_o(ready6)
  );

  // Inputs are driven and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({done8, ready8, hi8, lo8} !== {1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_w8: got done=%b ready=%b prod=%h, want done=0 ready=1 prod=0000",
               done8, ready8, {hi8, lo8});
    end
    n_checks++;
    if ({done6, ready6, hi6, lo6} !== {1'b0, 1'b1, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_w6: got done=%b ready=%b prod=%h, want done=0 ready=1 prod=000",
               done6, ready6, {hi6, lo6});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mul_square();
    logic [7:0] ta[6] = '{8'hFF, 8'h00, 8'h01, 8'h0F, 8'hFF, 8'h9C};
    logic [7:0] tb[6] = '{8'hFF, 8'h5A, 8'hC3, 8'hAA, 8'h00, 8'h3B};
    logic       ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      a8 = ta[i]; b8 = tb[i]; sq8 = ts[i]; strobe8 = 1'b1;
      e = ts[i] ? ({8'h00, ta[i]} * {8'h00, ta[i]}) : ({8'h00, ta[i]} * {8'h00, tb[i]});
      exp8_q.push_back(e);
      tick();
      strobe8 = 1'b0;
      // Scramble the inputs so that only the captured copies can give the right answer.
      a8 = 8'($urandom); b8 = 8'($urandom); sq8 = 1'($urandom);
      for (int c = 1; c <= 4; c++) begin
        n_checks++;
        if ({done8, ready8, hi8, lo8} !== {1'b0, 1'b0, 16'h0000}) begin
          n_fail++;
          $display("FAIL mul_busy[%0d] c=%0d: got done=%b ready=%b prod=%h, want 0 0 0000",
                   i, c, done8, ready8, {hi8, lo8});
        end
        tick();
      end
      n_checks++;
      if ({done8, ready8} !== 2'b11) begin
        n_fail++;
        $display("FAIL mul_done[%0d]: got done=%b ready=%b, want 1 1", i, done8, ready8);
      end else begin
        e = exp8_q.pop_front();
        n_checks++;
        if ({hi8, lo8} !== e) begin
          n_fail++;
          $display("FAIL mul_prod[%0d]: got %h, want %h", i, {hi8, lo8}, e);
        end
      end
      tick();
      n_checks++;
      if ({done8, hi8, lo8} !== {1'b0, 16'h0000}) begin
        n_fail++;
        $display("FAIL mul_after[%0d]: got done=%b prod=%h, want 0 0000", i, done8, {hi8, lo8});
      end
    end
    exp8_q.delete();
  endtask

  task automatic test_restrobe();
    int unsigned pulses = 0;
    logic [15:0] e;
    a8 = 8'd3; b8 = 8'd5; sq8 = 1'b0; strobe8 = 1'b1;
    tick();
    strobe8 = 1'b0;
    tick();
    a8 = 8'h80; b8 = 8'h02; strobe8 = 1'b1;
    exp8_q.push_back(16'h0100);
    tick();
    strobe8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (done8) pulses++;
      n_checks++;
      if (done8 !== (c == 5)) begin
        n_fail++;
        $display("FAIL restrobe_done c=%0d: got %b, want %b", c, done8, (c == 5));
      end
      if (c == 5 && done8 && exp8_q.size() > 0) begin
        e = exp8_q.pop_front();
        n_checks++;
        if ({hi8, lo8} !== e) begin
          n_fail++;
          $display("FAIL restrobe_prod: got %h, want %h", {hi8, lo8}, e);
        end
      end
      tick();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL restrobe_pulses: got %0d, want 1", pulses);
    end
    exp8_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    a8 = 8'h77; b8 = 8'h99; sq8 = 1'b0; strobe8 = 1'b1;
    tick();
    strobe8 = 1'b0;
    tick();
    reset = 1'b1;
    strobe8 = 1'b1;
    tick();
    reset = 1'b0;
    strobe8 = 1'b0;
    n_checks++;
    if ({done8, ready8} !== 2'b01) begin
      n_fail++;
      $display("FAIL resetmid_state: got done=%b ready=%b, want 0 1", done8, ready8);
    end
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if ({done8, ready8} !== 2'b01) begin
        n_fail++;
        $display("FAIL resetmid_quiet c=%0d: got done=%b ready=%b, want 0 1", c, done8, ready8);
      end
      tick();
    end
    a8 = 8'h12; b8 = 8'h34; strobe8 = 1'b1;
    exp8_q.push_back(16'h03A8);
    tick();
    strobe8 = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++;
    if (done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL resetmid_fresh_done: got %b, want 1", done8);
    end else begin
      e = exp8_q.pop_front();
      n_checks++;
      if ({hi8, lo8} !== e) begin
        n_fail++;
        $display("FAIL resetmid_fresh_prod: got %h, want %h", {hi8, lo8}, e);
      end
    end
    tick();
    exp8_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    a8 = 8'hAB; b8 = 8'hCD; sq8 = 1'b0; strobe8 = 1'b1;
    exp8_q.push_back(16'h88EF);
    tick();
    strobe8 = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    n_checks++;
    if ({done8, ready8} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_done1: got done=%b ready=%b, want 1 1", done8, ready8);
    end else begin
      e = exp8_q.pop_front();
      n_checks++;
      if ({hi8, lo8} !== e) begin
        n_fail++;
        $display("FAIL b2b_prod1: got %h, want %h", {hi8, lo8}, e);
      end
    end
    // Start the next operation during the done cycle.
    a8 = 8'h37; b8 = 8'h9E; strobe8 = 1'b1;
    exp8_q.push_back(16'h21F2);
    tick();
    strobe8 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if ({done8, ready8} !== 2'b00) begin
        n_fail++;
        $display("FAIL b2b_busy c=%0d: got done=%b ready=%b, want 0 0", c, done8, ready8);
      end
      tick();
    end
    n_checks++;
    if (done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done2: got %b, want 1", done8);
    end else begin
      e = exp8_q.pop_front();
      n_checks++;
      if ({hi8, lo8} !== e) begin
        n_fail++;
        $display("FAIL b2b_prod2: got %h, want %h", {hi8, lo8}, e);
      end
    end
    tick();
    exp8_q.delete();
  endtask

  task automatic test_random_w6();
    logic [5:0]  ra, rb;
    logic        rs;
    logic [11:0] e;
    for (int i = 0; i < 24; i++) begin
      ra = 6'($urandom); rb = 6'($urandom); rs = 1'($urandom);
      a6 = ra; b6 = rb; sq6 = rs; strobe6 = 1'b1;
      exp6_q.push_back(rs ? ({6'h00, ra} * {6'h00, ra}) : ({6'h00, ra} * {6'h00, rb}));
      tick();
      strobe6 = 1'b0;
      a6 = 6'($urandom); b6 = 6'($urandom); sq6 = 1'($urandom);
      for (int c = 1; c <= 3; c++) begin
        n_checks++;
        if ({done6, ready6, hi6, lo6} !== {1'b0, 1'b0, 12'h000}) begin
          n_fail++;
          $display("FAIL w6_busy[%0d] c=%0d: got done=%b ready=%b prod=%h, want 0 0 000",
                   i, c, done6, ready6, {hi6, lo6});
        end
        tick();
      end
      n_checks++;
      if ({done6, ready6} !== 2'b11) begin
        n_fail++;
        $display("FAIL w6_done[%0d]: got done=%b ready=%b, want 1 1", i, done6, ready6);
      end else begin
        e = exp6_q.pop_front();
        n_checks++;
        if ({hi6, lo6} !== e) begin
          n_fail++;
          $display("FAIL w6_prod[%0d]: got %h, want %h", i, {hi6, lo6}, e);
        end
      end
      // Either chain the next strobe into the done cycle or leave one idle cycle.
      if ($urandom_range(1, 0) == 0) begin
        tick();
        n_checks++;
        if ({done6, ready6} !== 2'b01) begin
          n_fail++;
          $display("FAIL w6_idle[%0d]: got done=%b ready=%b, want 0 1", i, done6, ready6);
        end
      end
    end
    tick();
    exp6_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    a8 = '0; b8 = '0; strobe8 = 1'b0; sq8 = 1'b0;
    a6 = '0; b6 = '0; strobe6 = 1'b0; sq6 = 1'b0;
    tick();
    test_reset();
    test_mul_square();
    test_restrobe();
    test_reset_mid();
    test_back_to_back();
    test_random_w6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
